// File: rtl/bo_datapath_if.sv
// bo_datapath_if: bundle of the control word, external operand and
// register/status outputs exchanged with the operational datapath.
//   master : drives x_in and the control word (LX, LS, LH, H, M0, M1, M2),
//            observes x_q, s_q, h_q, result, done, ovf.
//   slave  : the datapath itself; consumes the control word and data,
//            drives the register and status outputs.
interface bo_datapath_if #(
  parameter int W = 8
);
  logic [W-1:0] x_in;
  logic         LX;
  logic         LS;
  logic         LH;
  logic         H;
  logic [1:0]   M0;
  logic [1:0]   M1;
  logic [1:0]   M2;
  logic [W-1:0] x_q;
  logic [W-1:0] s_q;
  logic [W-1:0] h_q;
  logic [W-1:0] result;
  logic         done;
  logic         ovf;

  modport master (
    output x_in, LX, LS, LH, H, M0, M1, M2,
    input  x_q, s_q, h_q, result, done, ovf
  );

  modport slave (
    input  x_in, LX, LS, LH, H, M0, M1, M2,
    output x_q, s_q, h_q, result, done, ovf
  );
endinterface

// File: rtl/bo_datapath.sv
// bo_datapath: operational datapath driven by a per-cycle control word.
// Holds working registers X, S, H, an add/subtract ALU with operand and
// write-back multiplexers, a sticky carry/borrow flag and a result capture
// stage that publishes S after every N_LS loads of S.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   bus    - bo_datapath_if slave: x_in + control word in;
//            x_q, s_q, h_q, result, done, ovf out
module bo_datapath #(
  parameter int W    = 8,
  parameter int K0   = 1,
  parameter int K1   = 2,
  parameter int N_LS = 3
) (
  input  logic          clk,
  input  logic          reset,
  bo_datapath_if.slave  bus
);

  localparam int CW = (N_LS + 1 > 2) ? $clog2(N_LS + 1) : 1;

  logic [W-1:0]  x_reg, s_reg, h_reg, result_reg;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          done_reg, ovf_reg;

  logic [W-1:0]  a_op, b_op, wb, alu_shr;
  logic [W:0]    alu;
  logic          ovf_set, capture;

  // Operand A select
  always_comb begin
    a_op = x_reg;
    unique case (bus.M0)
      2'd0: a_op = x_reg;
      2'd1: a_op = s_reg;
      2'd2: a_op = h_reg;
      2'd3: a_op = W'(K0);
    endcase
  end

  // Operand B select
  always_comb begin
    b_op = x_reg;
    unique case (bus.M1)
      2'd0: b_op = x_reg;
      2'd1: b_op = bus.x_in;
      2'd2: b_op = s_reg;
      2'd3: b_op = W'(K1);
    endcase
  end

  // Bit W is carry-out on add and borrow (A<B) on subtract.
  assign alu = bus.H ? ({1'b0, a_op} + {1'b0, b_op})
                     : ({1'b0, a_op} - {1'b0, b_op});

  // Logical right shift of the W-bit result only; the carry never shifts in.
  genvar gi;
  generate
    for (gi = 0; gi < W - 1; gi++) begin : g_shr
      assign alu_shr[gi] = alu[gi+1];
    end
  endgenerate
  assign alu_shr[W-1] = 1'b0;

  // Write-back select
  always_comb begin
    wb = alu[W-1:0];
    unique case (bus.M2)
      2'd0: wb = alu[W-1:0];
      2'd1: wb = bus.x_in;
      2'd2: wb = '0;
      2'd3: wb = alu_shr;
    endcase
  end

  // Only ALU-derived write-backs that actually land in a register flag overflow.
  assign ovf_set = (bus.LS | bus.LH) && (bus.M2 == 2'd0 || bus.M2 == 2'd3) && alu[W];

  // The load that brings the count to N_LS is the capturing one.
  assign capture = bus.LS && (cnt_reg == CW'(N_LS - 1));

  always_comb begin
    cnt_next = cnt_reg;
    if (bus.LS) begin
      cnt_next = capture ? '0 : cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_reg      <= '0;
      s_reg      <= '0;
      h_reg      <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
      done_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      if (bus.LX) x_reg <= bus.x_in;
      if (bus.LS) s_reg <= wb;
      if (bus.LH) h_reg <= wb;
      cnt_reg  <= cnt_next;
      done_reg <= capture;
      if (capture) result_reg <= wb;
      // Set has priority over the clear caused by loading X.
      if (ovf_set)     ovf_reg <= 1'b1;
      else if (bus.LX) ovf_reg <= 1'b0;
    end
  end

  assign bus.x_q    = x_reg;
  assign bus.s_q    = s_reg;
  assign bus.h_q    = h_reg;
  assign bus.result = result_reg;
  assign bus.done   = done_reg;
  assign bus.ovf    = ovf_reg;

endmodule

// File: tb/tb_bo_datapath.sv
// tb_bo_datapath: table-driven directed test for bo_datapath (W=8, K0=1,
// K1=2, N_LS=3) plus hand-written reset sequences.
module tb_bo_datapath;

  logic clk;
  logic reset;

  bo_datapath_if #(.W(8)) bus ();

  bo_datapath #(.W(8), .K0(1), .K1(2), .N_LS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       pre_reset;
    bit [7:0] x_in;
    bit       lx, ls, lh, h;
    bit [1:0] m0, m1, m2;
    bit [7:0] ex, es, eh, eres;
    bit       edone, eovf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t v(bit pr, bit [7:0] xin, bit lx, bit ls, bit lh, bit h,
                             bit [1:0] m0, bit [1:0] m1, bit [1:0] m2,
                             bit [7:0] ex, bit [7:0] es, bit [7:0] eh, bit [7:0] eres,
                             bit edone, bit eovf);
    vec_t r;
    r.pre_reset = pr; r.x_in = xin; r.lx = lx; r.ls = ls; r.lh = lh; r.h = h;
    r.m0 = m0; r.m1 = m1; r.m2 = m2;
    r.ex = ex; r.es = es; r.eh = eh; r.eres = eres; r.edone = edone; r.eovf = eovf;
    return r;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, bit [7:0] ex, bit [7:0] es, bit [7:0] eh,
                         bit [7:0] eres, bit edone, bit eovf);
    chk({tag, " x_q"},    int'(bus.x_q),    int'(ex));
    chk({tag, " s_q"},    int'(bus.s_q),    int'(es));
    chk({tag, " h_q"},    int'(bus.h_q),    int'(eh));
    chk({tag, " result"}, int'(bus.result), int'(eres));
    chk({tag, " done"},   int'(bus.done),   int'(edone));
    chk({tag, " ovf"},    int'(bus.ovf),    int'(eovf));
  endtask

  task automatic idle_ctrl();
    bus.x_in = '0; bus.LX = 0; bus.LS = 0; bus.LH = 0; bus.H = 0;
    bus.M0 = '0; bus.M1 = '0; bus.M2 = '0;
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear
  // while reset is low, without any clock edge.
  task automatic reset_pulse(string tag);
    idle_ctrl();
    reset = 1'b0;
    #2;
    chk_all({tag, " async-reset"}, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    // Columns: pre_reset, x_in, LX, LS, LH, H, M0, M1, M2 | x, s, h, result, done, ovf
    vecs.push_back(v(0,   5, 1,0,0,0, 0,0,0,   5,  0,   0,  0, 0, 0)); // load X
    vecs.push_back(v(0,   3, 0,1,0,1, 0,1,0,   5,  8,   0,  0, 0, 0)); // S = X + x_in
    vecs.push_back(v(0,  10, 0,0,1,0, 1,1,0,   5,  8, 254,  0, 0, 1)); // H = S - 10, borrow
    vecs.push_back(v(0,   0, 0,0,0,0, 0,0,0,   5,  8, 254,  0, 0, 1)); // idle, sticky
    vecs.push_back(v(0,   0, 0,0,0,0, 0,0,0,   5,  8, 254,  0, 0, 1)); // idle, sticky
    vecs.push_back(v(0, 200, 1,0,0,0, 0,0,0, 200,  8, 254,  0, 0, 0)); // LX clears ovf
    vecs.push_back(v(0,   0, 0,1,1,1, 0,0,3, 200, 72,  72,  0, 0, 1)); // (400 mod 256)>>1
    vecs.push_back(v(1,   4, 0,1,0,0, 0,0,1,   0,  4,   0,  0, 0, 0)); // reset, S = 4
    vecs.push_back(v(0,   5, 0,1,0,1, 1,1,0,   0,  9,   0,  0, 0, 0)); // S = 9
    vecs.push_back(v(0,   8, 0,1,0,1, 1,1,0,   0, 17,   0, 17, 1, 0)); // S = 17, capture
    vecs.push_back(v(0,   0, 0,1,0,0, 0,0,2,   0,  0,   0, 17, 0, 0)); // 4th load, no done
    vecs.push_back(v(0,   0, 0,0,1,1, 3,3,0,   0,  0,   3, 17, 0, 0)); // K0 + K1
    vecs.push_back(v(0,   0, 0,0,1,0, 3,3,2,   0,  0,   0, 17, 0, 0)); // zero path, no ovf
    vecs.push_back(v(0,   7, 1,0,1,0, 3,3,0,   7,  0, 255, 17, 0, 1)); // set beats LX clear
    vecs.push_back(v(0,   9, 1,1,0,1, 0,3,0,   9,  9, 255, 17, 0, 0)); // wb uses old X (7+2)
    vecs.push_back(v(1,   1, 0,1,0,0, 0,0,1,   0,  1,   0,  0, 0, 0)); // reset after 2 loads
    vecs.push_back(v(0,   2, 0,1,0,0, 0,0,1,   0,  2,   0,  0, 0, 0));
    vecs.push_back(v(0,   3, 0,1,0,0, 0,0,1,   0,  3,   0,  3, 1, 0)); // 3rd load after reset
    vecs.push_back(v(0,   4, 0,1,0,0, 0,0,1,   0,  4,   0,  3, 0, 0)); // back-to-back run
    vecs.push_back(v(0,   5, 0,1,0,0, 0,0,1,   0,  5,   0,  3, 0, 0));
    vecs.push_back(v(0,   6, 0,1,0,0, 0,0,1,   0,  6,   0,  6, 1, 0));
    vecs.push_back(v(0,   0, 0,0,0,0, 0,0,0,   0,  6,   0,  6, 0, 0)); // done drops

    // Reset held across edges with random controls.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.x_in = 8'($urandom); bus.LX = 1'($urandom); bus.LS = 1'($urandom);
      bus.LH = 1'($urandom); bus.H = 1'($urandom); bus.M0 = 2'($urandom);
      bus.M1 = 2'($urandom); bus.M2 = 2'($urandom);
      @(posedge clk); #1;
    end
    chk_all("reset-held", 0, 0, 0, 0, 0, 0);
    idle_ctrl();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk_all($sformatf("idle%0d", i), 0, 0, 0, 0, 0, 0);
    end
    $display("reset/idle: all registers zero");

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t t;
      int   f0;
      t  = vecs[i];
      f0 = n_fail;
      if (t.pre_reset) reset_pulse($sformatf("v%0d", i));
      bus.x_in = t.x_in; bus.LX = t.lx; bus.LS = t.ls; bus.LH = t.lh; bus.H = t.h;
      bus.M0 = t.m0; bus.M1 = t.m1; bus.M2 = t.m2;
      @(posedge clk); #1;
      chk_all($sformatf("v%0d", i), t.ex, t.es, t.eh, t.eres, t.edone, t.eovf);
      $display("v%0d: x=%0d s=%0d h=%0d result=%0d done=%0d ovf=%0d %s",
               i, bus.x_q, bus.s_q, bus.h_q, bus.result, bus.done, bus.ovf,
               (n_fail == f0) ? "ok" : "bad");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
